// File: rtl/gpr_pkg.sv
// Shared definitions for the multi-port GPR file: default sizes, depth helper,
// parity helper and the write-request bundle.
package gpr_pkg;

  localparam int unsigned GPR_DATA_W = 16;
  localparam int unsigned GPR_ADDR_W = 3;
  localparam int unsigned GPR_N_RD   = 2;

  // Number of registers addressed by an addr_w-bit index.
  function automatic int unsigned gpr_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Even-parity bit: makes the total count of ones (data + parity) even.
  // Callers zero-extend their data, which leaves the parity unchanged.
  function automatic logic gpr_even_parity(input logic [63:0] data);
    return ^data;
  endfunction

  // Write request at the default geometry.
  typedef struct packed {
    logic                  en;
    logic [GPR_ADDR_W-1:0] addr;
    logic [GPR_DATA_W-1:0] data;
  } gpr_wr_req_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard for outstanding loads.
// Priority per register: reset, flush, set (new load), load-return clear, hold.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sb_set_en,
  input  logic [ADDR_W-1:0]            sb_set_addr,
  input  logic                         sb_flush,
  input  logic                         wr1_en,
  input  logic [ADDR_W-1:0]            wr1_addr,
  output logic [gpr_depth(ADDR_W)-1:0] busy_vec
);

  localparam int unsigned DEPTH = gpr_depth(ADDR_W);

  logic [DEPTH-1:0] busy_q, busy_d;

  // Next busy state; a same-cycle set beats a clear since the new load supersedes the old.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sb_flush) begin
        busy_d[i] = 1'b0;
      end else if (sb_set_en && (sb_set_addr == ADDR_W'(i)) &&
                   !((ZERO_R0 != 0) && (i == 0))) begin
        busy_d[i] = 1'b1;
      end else if (wr1_en && (wr1_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  // Scoreboard register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port register file: two write ports (ALU, load return), N_RD bypassed
// read ports and a load scoreboard. Optional GPR_PARITY_EN adds per-register
// even parity and the rd_perr output.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W  = GPR_DATA_W,
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned N_RD    = GPR_N_RD,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr0_en,
  input  logic [ADDR_W-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]            wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_W-1:0]            wr1_addr,
  input  logic [DATA_W-1:0]            wr1_data,
  input  logic                         sb_set_en,
  input  logic [ADDR_W-1:0]            sb_set_addr,
  input  logic                         sb_flush,
  input  logic [N_RD*ADDR_W-1:0]       rd_addr,
  output logic [N_RD*DATA_W-1:0]       rd_data,
  output logic [N_RD-1:0]              rd_busy,
`ifdef GPR_PARITY_EN
  output logic [N_RD-1:0]              rd_perr,
`endif
  output logic [gpr_depth(ADDR_W)-1:0] busy_vec
);

  localparam int unsigned DEPTH = gpr_depth(ADDR_W);

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t wr0, wr1;
  logic    wr0_ok, wr1_ok;

  assign wr0 = '{en: wr0_en, addr: wr0_addr, data: wr0_data};
  assign wr1 = '{en: wr1_en, addr: wr1_addr, data: wr1_data};

  // Writes to a hardwired r0 are dropped.
  assign wr0_ok = wr0.en & ~((ZERO_R0 != 0) & (wr0.addr == '0));
  assign wr1_ok = wr1.en & ~((ZERO_R0 != 0) & (wr1.addr == '0));

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Storage next state; wr0 applied last so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    if (wr1_ok) mem_d[wr1.addr] = wr1.data;
    if (wr0_ok) mem_d[wr0.addr] = wr0.data;
  end

  // Storage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef GPR_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;

  // Parity next state, tracking the same write priority as the data.
  always_comb begin
    par_d = par_q;
    if (wr1_ok) par_d[wr1.addr] = gpr_even_parity(64'(wr1.data));
    if (wr0_ok) par_d[wr0.addr] = gpr_even_parity(64'(wr0.data));
  end

  // Parity register; zero is the correct parity of reset data.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  gpr_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .busy_vec    (busy_vec)
  );

  for (genvar k = 0; k < int'(N_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_r0;
    logic              hit0;
    logic              hit1;

    assign addr  = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_r0 = (ZERO_R0 != 0) && (addr == '0);
    assign hit0  = wr0.en && (wr0.addr == addr);
    assign hit1  = wr1.en && (wr1.addr == addr);

    // Read mux: hardwired zero, then ALU bypass, then load bypass, then storage.
    always_comb begin
      if (is_r0) begin
        data = '0;
      end else if (hit0) begin
        data = wr0.data;
      end else if (hit1) begin
        data = wr1.data;
      end else begin
        data = mem_q[addr];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    // A returning load is bypassed, so its register reads as not busy.
    assign rd_busy[k] = ~is_r0 & busy_vec[addr] & ~hit1;

`ifdef GPR_PARITY_EN
    assign rd_perr[k] = ~is_r0 & ~hit0 & ~hit1 &
                        (gpr_even_parity(64'(mem_q[addr])) != par_q[addr]);
`endif
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: two instances (ZERO_R0=0 and ZERO_R0=1) driven by the
// same stimulus, checked against an array-based reference model. Directed
// scenarios first, then random traffic. Define GPR_PARITY_EN for parity checks.
module tb_gpr_file_mp;
  import gpr_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  gpr_wr_req_t       w0, w1;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic              sb_flush;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rdd   [2];
  logic [NR-1:0]     rbusy [2];
  logic [DEPTH-1:0]  bvec  [2];
`ifdef GPR_PARITY_EN
  logic [NR-1:0]     perr  [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one copy per instance (index 1 = hardwired r0).
  logic [DW-1:0]    m_reg  [2][DEPTH];
  logic [DEPTH-1:0] m_busy [2];

  always #5 clk = ~clk;

  gpr_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .wr0_en      (w0.en),
    .wr0_addr    (w0.addr),
    .wr0_data    (w0.data),
    .wr1_en      (w1.en),
    .wr1_addr    (w1.addr),
    .wr1_data    (w1.data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .rd_addr     (rd_addr),
    .rd_data     (rdd[0]),
    .rd_busy     (rbusy[0]),
`ifdef GPR_PARITY_EN
    .rd_perr     (perr[0]),
`endif
    .busy_vec    (bvec[0])
  );

  gpr_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .wr0_en      (w0.en),
    .wr0_addr    (w0.addr),
    .wr0_data    (w0.data),
    .wr1_en      (w1.en),
    .wr1_addr    (w1.addr),
    .wr1_data    (w1.data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .rd_addr     (rd_addr),
    .rd_data     (rdd[1]),
    .rd_busy     (rbusy[1]),
`ifdef GPR_PARITY_EN
    .rd_perr     (perr[1]),
`endif
    .busy_vec    (bvec[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int d, input logic [AW-1:0] a);
    if (d == 1 && a == '0) return '0;
    if (w0.en && w0.addr == a) return w0.data;
    if (w1.en && w1.addr == a) return w1.data;
    return m_reg[d][a];
  endfunction

  function automatic logic exp_busy(input int d, input logic [AW-1:0] a);
    if (d == 1 && a == '0) return 1'b0;
    return m_busy[d][a] && !(w1.en && w1.addr == a);
  endfunction

  task automatic clear_inputs();
    rst         = 1'b0;
    w0          = '0;
    w1          = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
    sb_flush    = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Apply the clock edge to the model using the inputs held across the edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) m_reg[d][i] = '0;
        m_busy[d] = '0;
      end else begin
        if (w1.en && !(d == 1 && w1.addr == '0)) m_reg[d][w1.addr] = w1.data;
        if (w0.en && !(d == 1 && w0.addr == '0)) m_reg[d][w0.addr] = w0.data;
        if (sb_flush) begin
          m_busy[d] = '0;
        end else begin
          if (w1.en) m_busy[d][w1.addr] = 1'b0;
          if (sb_set_en && !(d == 1 && sb_set_addr == '0)) m_busy[d][sb_set_addr] = 1'b1;
        end
      end
    end
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic step(input bit do_check);
    #1;
    if (do_check) begin
      for (int d = 0; d < 2; d++) begin
        check_eq($sformatf("d%0d_busy_vec", d), 32'(bvec[d]), 32'(m_busy[d]));
        for (int k = 0; k < int'(NR); k++) begin
          logic [AW-1:0] a;
          a = rd_addr[k*AW +: AW];
          check_eq($sformatf("d%0d_rd%0d_data_a%0d", d, k, a),
                   32'(rdd[d][k*DW +: DW]), 32'(exp_data(d, a)));
          check_eq($sformatf("d%0d_rd%0d_busy_a%0d", d, k, a),
                   32'(rbusy[d][k]), 32'(exp_busy(d, a)));
`ifdef GPR_PARITY_EN
          check_eq($sformatf("d%0d_rd%0d_perr", d, k), 32'(perr[d][k]), 32'd0);
`endif
        end
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    clear_inputs();
    set_rd('0, '0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(DEPTH); i++) m_reg[d][i] = '0;
      m_busy[d] = '0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0);
    clear_inputs();

    // Reset clears storage written before it.
    w0 = '{en: 1'b1, addr: 3'd3, data: 16'h1234};
    set_rd(3'd3, 3'd3);
    step(1'b1);
    clear_inputs();
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("reset_r3", 32'(rdd[0][15:0]), 32'h0);
    check_eq("reset_busy_vec", 32'(bvec[0]), 32'h0);
    step(1'b1);

    // Same-cycle bypass, then the stored value.
    w0 = '{en: 1'b1, addr: 3'd5, data: 16'hBEEF};
    set_rd(3'd0, 3'd5);
    #1;
    check_eq("bypass_same_cycle", 32'(rdd[0][31:16]), 32'hBEEF);
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("bypass_stored", 32'(rdd[0][31:16]), 32'hBEEF);
    step(1'b1);

    // Write collision on a busy register.
    sb_set_en = 1'b1; sb_set_addr = 3'd2;
    step(1'b1);
    clear_inputs();
    w0 = '{en: 1'b1, addr: 3'd2, data: 16'h1111};
    w1 = '{en: 1'b1, addr: 3'd2, data: 16'h2222};
    step(1'b1);
    clear_inputs();
    set_rd(3'd2, 3'd0);
    #1;
    check_eq("collision_data", 32'(rdd[0][15:0]), 32'h1111);
    check_eq("collision_busy", 32'(bvec[0][2]), 32'h0);
    step(1'b1);

    // Scoreboard set, load return bypass, set beating clear.
    sb_set_en = 1'b1; sb_set_addr = 3'd4;
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("sb_set_r4", 32'(bvec[0][4]), 32'h1);
    w1 = '{en: 1'b1, addr: 3'd4, data: 16'h00AA};
    set_rd(3'd4, 3'd0);
    #1;
    check_eq("ld_return_busy", 32'(rbusy[0][0]), 32'h0);
    check_eq("ld_return_data", 32'(rdd[0][15:0]), 32'h00AA);
    step(1'b1);
    clear_inputs();
    sb_set_en = 1'b1; sb_set_addr = 3'd4;
    w1 = '{en: 1'b1, addr: 3'd4, data: 16'h0055};
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("set_beats_clear", 32'(bvec[0][4]), 32'h1);

    // Flush overrides a same-cycle set.
    sb_set_en = 1'b1; sb_set_addr = 3'd1;
    step(1'b1);
    sb_set_addr = 3'd6;
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("busy_before_flush", 32'(bvec[0]), 32'h52);
    sb_flush = 1'b1; sb_set_en = 1'b1; sb_set_addr = 3'd7;
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("flush_busy_vec", 32'(bvec[0]), 32'h0);

    // Hardwired r0 on dut1 only.
    w0 = '{en: 1'b1, addr: 3'd0, data: 16'hFFFF};
    sb_set_en = 1'b1; sb_set_addr = 3'd0;
    set_rd(3'd0, 3'd0);
    #1;
    check_eq("r0_no_bypass", 32'(rdd[1][15:0]), 32'h0);
    step(1'b1);
    clear_inputs();
    #1;
    check_eq("r0_reads_zero", 32'(rdd[1][15:0]), 32'h0);
    check_eq("r0_never_busy", 32'(bvec[1][0]), 32'h0);
    check_eq("r0_plain_data", 32'(rdd[0][15:0]), 32'hFFFF);
    check_eq("r0_plain_busy", 32'(bvec[0][0]), 32'h1);
    step(1'b1);

`ifdef GPR_PARITY_EN
    // Corrupt stored r3 bit 0 without touching its parity.
    set_rd(3'd3, 3'd0);
    dut0.mem_q[3][0] = ~dut0.mem_q[3][0];
    #1;
    check_eq("parity_error", 32'(perr[0][0]), 32'h1);
    dut0.mem_q[3][0] = ~dut0.mem_q[3][0];
    #1;
    check_eq("parity_restored", 32'(perr[0][0]), 32'h0);
`endif

    // Random traffic, read addresses biased toward the write targets.
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      rst         = ($urandom_range(0, 63) == 0);
      w0.en       = ($urandom_range(0, 1) == 1);
      w0.addr     = AW'($urandom_range(0, DEPTH - 1));
      w0.data     = DW'($urandom);
      w1.en       = ($urandom_range(0, 2) == 0);
      w1.addr     = AW'($urandom_range(0, DEPTH - 1));
      w1.data     = DW'($urandom);
      sb_set_en   = ($urandom_range(0, 2) == 0);
      sb_set_addr = AW'($urandom_range(0, DEPTH - 1));
      sb_flush    = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < int'(NR); k++) begin
        case ($urandom_range(0, 3))
          0:       rd_addr[k*AW +: AW] = w0.addr;
          1:       rd_addr[k*AW +: AW] = w1.addr;
          default: rd_addr[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        endcase
      end
      step(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
